// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-control bundle between the PC sequencer and its IF-stage neighbours
interface pc_sequencer_if #(
    parameter int width = 10
);
    logic             start;
    logic             stall;
    logic             branch_taken;
    logic [width-1:0] branch_target;
    logic             jump;
    logic [width-1:0] jump_target;
    logic             halt;
    logic [width-1:0] adder_sum;
    logic [width-1:0] adder_a;
    logic [width-1:0] adder_b;
    logic [width-1:0] pc;
    logic [width-1:0] pc_plus;
    logic             fetch_valid;
    logic             flush;
    logic [1:0]       state_o;

    modport master (
        input  start, stall, branch_taken, branch_target, jump, jump_target, halt, adder_sum,
        output adder_a, adder_b, pc, pc_plus, fetch_valid, flush, state_o
    );

    modport slave (
        output start, stall, branch_taken, branch_target, jump, jump_target, halt, adder_sum,
        input  adder_a, adder_b, pc, pc_plus, fetch_valid, flush, state_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction-fetch PC controller sequencing the external IF adder
module pc_sequencer #(
    parameter int width    = 10,
    parameter int INC      = 1,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    pc_sequencer_if.master  bus
);
    localparam logic [width-1:0] INC_W   = width'(INC);
    localparam logic [width-1:0] RESET_W = width'(RESET_PC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [width-1:0] pc_q;
    logic [width-1:0] pc_nx;
    logic [width-1:0] pc_plus_q;
    logic [width-1:0] pc_plus_nx;
    logic             flush_q;
    logic             flush_nx;

    // State register; reset always returns to IDLE, abandoning any redirect in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: start leaves IDLE, halt is terminal until reset.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.start) state_nx = ST_RUN;
            ST_RUN:  if (bus.halt)  state_nx = ST_HALT;
            ST_HALT: state_nx = ST_HALT;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Next PC selection: halt > jump > branch > stall > sequential; redirects beat stall.
    always_comb begin
        pc_nx      = pc_q;
        pc_plus_nx = pc_plus_q;
        flush_nx   = 1'b0;
        case (state)
            ST_IDLE: begin
                // First fetch is the current pc, so only its successor needs loading.
                if (bus.start) pc_plus_nx = bus.adder_sum;
            end
            ST_RUN: begin
                if (bus.halt) begin
                    pc_nx = pc_q;
                end else if (bus.jump) begin
                    pc_nx      = bus.jump_target;
                    pc_plus_nx = bus.jump_target + INC_W;
                    flush_nx   = 1'b1;
                end else if (bus.branch_taken) begin
                    pc_nx      = bus.branch_target;
                    pc_plus_nx = bus.branch_target + INC_W;
                    flush_nx   = 1'b1;
                end else if (!bus.stall) begin
                    // adder_sum is pc+INC; the new pc_plus is one further step ahead.
                    pc_nx      = bus.adder_sum;
                    pc_plus_nx = bus.adder_sum + INC_W;
                end
            end
            default: begin
                pc_nx = pc_q;
            end
        endcase
    end

    // PC, pc_plus and flush registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_W;
            pc_plus_q <= RESET_W;
            flush_q   <= 1'b0;
        end else begin
            pc_q      <= pc_nx;
            pc_plus_q <= pc_plus_nx;
            flush_q   <= flush_nx;
        end
    end

    // Outputs: adder operands are tied to pc and the increment; fetches are valid only in RUN.
    always_comb begin
        bus.adder_a     = pc_q;
        bus.adder_b     = INC_W;
        bus.pc          = pc_q;
        bus.pc_plus     = pc_plus_q;
        bus.flush       = flush_q;
        bus.fetch_valid = (state == ST_RUN);
        bus.state_o     = state;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with randomized and directed fetch traffic
module tb_pc_sequencer;
    localparam int W   = 10;
    localparam int INC = 1;
    localparam int RPC = 0;

    logic clk = 1'b0;
    logic rst;

    pc_sequencer_if #(.width(W)) bus ();

    pc_sequencer #(.width(W), .INC(INC), .RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External IF adder: combinational, modulo 2^W.
    assign bus.adder_sum = bus.adder_a + bus.adder_b;

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] pp;
        logic         fv;
        logic         fl;
        logic [1:0]   st;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    // Reference model: mode 0 idle, 1 run, 2 halt.
    int           m_mode;
    logic [W-1:0] m_pc;
    logic         m_fl;

    function automatic void m_reset();
        m_mode = 0;
        m_pc   = W'(RPC);
        m_fl   = 1'b0;
    endfunction

    function automatic void m_step(input logic s, input logic stl, input logic b, input logic [W-1:0] bt,
                                   input logic j, input logic [W-1:0] jt, input logic h);
        m_fl = 1'b0;
        if (m_mode == 0) begin
            if (s) m_mode = 1;
        end else if (m_mode == 1) begin
            if (h) m_mode = 2;
            else if (j) begin m_pc = jt; m_fl = 1'b1; end
            else if (b) begin m_pc = bt; m_fl = 1'b1; end
            else if (!stall_hold(stl)) m_pc = W'((int'(m_pc) + INC) % (1 << W));
        end
    endfunction

    function automatic logic stall_hold(input logic stl);
        return stl;
    endfunction

    // Outside IDLE the fetched pc always carries its successor; IDLE is only reached via reset.
    function automatic exp_t mk_exp();
        exp_t x;
        x.pc = m_pc;
        x.pp = (m_mode == 0) ? W'(RPC) : W'((int'(m_pc) + INC) % (1 << W));
        x.fv = (m_mode == 1);
        x.fl = m_fl;
        x.st = 2'(m_mode);
        return x;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h required %0h", nm, $time, act, req);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic stl, input logic b, input logic [W-1:0] bt,
                       input logic j, input logic [W-1:0] jt, input logic h);
        @(posedge clk);
        #1;
        rst               = r;
        bus.start         = s;
        bus.stall         = stl;
        bus.branch_taken  = b;
        bus.branch_target = bt;
        bus.jump          = j;
        bus.jump_target   = jt;
        bus.halt          = h;
        if (r) m_reset();
        exp_q.push_back(mk_exp());
        mon_en = 1'b1;
        if (r) m_reset();
        else   m_step(s, stl, b, bt, j, jt, h);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // Reset asserted between edges; outputs must change before the next edge.
    task automatic async_rst();
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.stall    = 1'b0;
        bus.branch_taken = 1'b0;
        bus.jump     = 1'b0;
        bus.halt     = 1'b0;
        #1;
        m_reset();
        exp_q.push_back(mk_exp());
    endtask

    task automatic run_to(input logic [W-1:0] target);
        int guard = 0;
        while (m_pc != target && guard < 1100) begin
            idle(1);
            guard++;
        end
        if (m_pc != target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_to: model pc %0h never reached %0h", m_pc, target);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs, pop the expected entry and compare.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty at %0t: got no entry required one", $time);
            end else begin
                e = exp_q.pop_front();
                chk("pc",          bus.pc,               e.pc);
                chk("pc_plus",     bus.pc_plus,          e.pp);
                chk("fetch_valid", W'(bus.fetch_valid),  W'(e.fv));
                chk("flush",       W'(bus.flush),        W'(e.fl));
                chk("state",       W'(bus.state_o),      W'(e.st));
                chk("adder_a",     bus.adder_a,          e.pc);
                chk("adder_b",     bus.adder_b,          W'(INC));
            end
        end
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        rst               = 1'b1;
        bus.start         = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.jump          = 1'b0;
        bus.jump_target   = '0;
        bus.halt          = 1'b0;
        m_reset();

        // Reset, start, sequential fetch
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        idle(5);

        // Stall for three cycles at pc 7
        run_to(W'(7));
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        idle(2);

        // Branch with stall at pc 4
        async_rst();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        run_to(W'(4));
        cyc(1'b0, 1'b0, 1'b1, 1'b1, W'(10'h20), 1'b0, '0, 1'b0);
        idle(2);

        // Jump beats branch
        cyc(1'b0, 1'b0, 1'b0, 1'b1, W'(10'h10), 1'b1, W'(10'h3F), 1'b0);
        idle(2);

        // Wrap-around at the top of the address space
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, W'(10'h3FF), 1'b0);
        idle(3);

        // Halt at pc 9; inputs ignored; async reset recovers
        async_rst();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        run_to(W'(9));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, W'(10'h55), 1'b1, W'(10'h5), 1'b0);
        idle(2);
        async_rst();
        idle(2);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) < 2) begin
                async_rst();
            end else begin
                cyc(1'b0,
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 5) == 0),
                    W'($urandom),
                    ($urandom_range(0, 9) == 0),
                    W'($urandom),
                    ($urandom_range(0, 49) == 0));
            end
        end

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
